// File: rtl/cbfp_denorm.sv
// cbfp_denorm: undoes the per-block CBFP normalisation at the FFT output.
//   A small FIFO queues the signed shift the CBFP stage applied to each
//   64-sample block. Each 16-lane complex beat of that block gets the inverse
//   shift (>>> s), with round-half-up on right shifts. The result is then
//   saturated to OUT_W. Latency is one cycle from valid_in to valid_out.
// Ports:
//   clk, rst                    clock, async active-high reset
//   exp_valid/exp_in/exp_ready  exponent push (accepted on valid && ready)
//   valid_in, data_re_in/_im_in NCHAN packed IN_W-bit signed lanes, gaps allowed
//   valid_out, blk_first        registered beat strobe, first beat of block
//   data_re_out/_im_out         NCHAN packed OUT_W-bit signed lanes (hold when idle)
//   err_underflow               sticky: block began with no queued exponent
//   err_overflow                sticky: exponent pushed while FIFO full (dropped)
module cbfp_denorm #(
  parameter int NCHAN     = 16,
  parameter int IN_W      = 11,
  parameter int OUT_W     = 16,
  parameter int EXP_W     = 5,
  parameter int BLK_BEATS = 4,
  parameter int EXP_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   exp_valid,
  input  logic [EXP_W-1:0]       exp_in,
  output logic                   exp_ready,
  input  logic                   valid_in,
  input  logic [NCHAN*IN_W-1:0]  data_re_in,
  input  logic [NCHAN*IN_W-1:0]  data_im_in,
  output logic                   valid_out,
  output logic                   blk_first,
  output logic [NCHAN*OUT_W-1:0] data_re_out,
  output logic [NCHAN*OUT_W-1:0] data_im_out,
  output logic                   err_underflow,
  output logic                   err_overflow
);

  localparam int PTR_W  = (EXP_DEPTH > 1) ? $clog2(EXP_DEPTH) : 1;
  localparam int CNT_W  = $clog2(EXP_DEPTH + 1);
  localparam int BEAT_W = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
  // Wide enough for a 15-bit left shift of an IN_W sample plus sign.
  localparam int WIDE_W = IN_W + 16;
  localparam int MAX_SHIFT = 15;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Exponent FIFO
  // ---------------------------------------------------------------------------
  logic [EXP_W-1:0] mem [EXP_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             push;
  logic             pop;
  logic             empty;
  logic [EXP_W-1:0] head_exp;

  state_t           state;
  state_t           state_nxt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] beat_cnt_nxt;
  logic [EXP_W-1:0] cur_exp;
  logic [EXP_W-1:0] cur_exp_nxt;
  logic             blk_start;
  logic [EXP_W-1:0] exp_eff;
  int               shift;

  logic [NCHAN*OUT_W-1:0] re_nxt;
  logic [NCHAN*OUT_W-1:0] im_nxt;

  assign push      = exp_valid && exp_ready;
  assign empty     = (count == '0);
  assign blk_start = valid_in && (state == IDLE);
  // A block start with nothing queued runs unscaled and flags underflow.
  // A push landing in that same cycle is not visible to it.
  assign pop       = blk_start && !empty;
  assign head_exp  = empty ? '0 : mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= exp_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      exp_ready <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count     <= count_nxt;
      exp_ready <= (count_nxt != CNT_W'(EXP_DEPTH));
    end
  end

  // ---------------------------------------------------------------------------
  // Block framing FSM, advanced by valid_in beats only
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    cur_exp_nxt  = cur_exp;
    if (valid_in) begin
      case (state)
        IDLE: begin
          cur_exp_nxt = head_exp;
          if (BLK_BEATS > 1) begin
            beat_cnt_nxt = BEAT_W'(1);
            state_nxt    = RUN;
          end
        end
        RUN: begin
          if (beat_cnt == BEAT_W'(BLK_BEATS - 1)) begin
            beat_cnt_nxt = '0;
            state_nxt    = IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + BEAT_W'(1);
          end
        end
        default: begin
          state_nxt    = IDLE;
          beat_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      cur_exp  <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      cur_exp  <= cur_exp_nxt;
    end
  end

  // The first beat of a block uses the FIFO head directly so the block needs
  // no extra cycle of setup; later beats use the latched copy.
  assign exp_eff = (state == IDLE) ? head_exp : cur_exp;

  always_comb begin
    shift = int'($signed(exp_eff));
    if (shift > MAX_SHIFT) begin
      shift = MAX_SHIFT;
    end
    if (shift < -MAX_SHIFT) begin
      shift = -MAX_SHIFT;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-lane inverse shift with rounding and saturation
  // ---------------------------------------------------------------------------
  function automatic logic [OUT_W-1:0] denorm(input logic [IN_W-1:0] x, input int s);
    logic signed [WIDE_W-1:0] xw;
    logic signed [WIDE_W-1:0] rnd;
    logic signed [WIDE_W-1:0] yw;
    logic [OUT_W-1:0]         res;
    xw  = {{(WIDE_W - IN_W){x[IN_W-1]}}, x};
    rnd = '0;
    if (s > 0) begin
      // Adding half an LSB before the arithmetic shift rounds ties upward.
      rnd = {{(WIDE_W - 1){1'b0}}, 1'b1} << (s - 1);
      yw  = (xw + rnd) >>> s;
    end else if (s < 0) begin
      yw = xw <<< (-s);
    end else begin
      yw = xw;
    end
    // In range when every bit above the OUT_W sign bit matches it.
    if ((&yw[WIDE_W-1:OUT_W-1]) || !(|yw[WIDE_W-1:OUT_W-1])) begin
      res = yw[OUT_W-1:0];
    end else if (yw[WIDE_W-1]) begin
      res = {1'b1, {(OUT_W - 1){1'b0}}};
    end else begin
      res = {1'b0, {(OUT_W - 1){1'b1}}};
    end
    return res;
  endfunction

  always_comb begin
    re_nxt = '0;
    im_nxt = '0;
    for (int i = 0; i < NCHAN; i++) begin
      re_nxt[i*OUT_W +: OUT_W] = denorm(data_re_in[i*IN_W +: IN_W], shift);
      im_nxt[i*OUT_W +: OUT_W] = denorm(data_im_in[i*IN_W +: IN_W], shift);
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers and sticky error flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out     <= 1'b0;
      blk_first     <= 1'b0;
      data_re_out   <= '0;
      data_im_out   <= '0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      valid_out <= valid_in;
      blk_first <= blk_start;
      if (valid_in) begin
        data_re_out <= re_nxt;
        data_im_out <= im_nxt;
      end
      if (blk_start && empty) begin
        err_underflow <= 1'b1;
      end
      if (exp_valid && !exp_ready) begin
        err_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cbfp_denorm.sv
// Directed bench for cbfp_denorm. It covers reset, rounding, saturation,
// FIFO full and empty cases, gappy input and a mid-block reset.
module tb_cbfp_denorm;
  localparam int NCHAN = 16;
  localparam int IN_W  = 11;
  localparam int OUT_W = 16;
  localparam int EXP_W = 5;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   exp_valid = 1'b0;
  logic [EXP_W-1:0]       exp_in = '0;
  logic                   exp_ready;
  logic                   valid_in = 1'b0;
  logic [NCHAN*IN_W-1:0]  data_re_in = '0;
  logic [NCHAN*IN_W-1:0]  data_im_in = '0;
  logic                   valid_out;
  logic                   blk_first;
  logic [NCHAN*OUT_W-1:0] data_re_out;
  logic [NCHAN*OUT_W-1:0] data_im_out;
  logic                   err_underflow;
  logic                   err_overflow;

  int checks = 0;
  int errors = 0;

  cbfp_denorm dut (
    .clk(clk), .rst(rst),
    .exp_valid(exp_valid), .exp_in(exp_in), .exp_ready(exp_ready),
    .valid_in(valid_in), .data_re_in(data_re_in), .data_im_in(data_im_in),
    .valid_out(valid_out), .blk_first(blk_first),
    .data_re_out(data_re_out), .data_im_out(data_im_out),
    .err_underflow(err_underflow), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [NCHAN*OUT_W-1:0] obs,
                         input logic [NCHAN*OUT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Even lanes carry a, odd lanes carry b.
  function automatic logic [NCHAN*IN_W-1:0] lanes_in(input logic [IN_W-1:0] a,
                                                     input logic [IN_W-1:0] b);
    logic [NCHAN*IN_W-1:0] v;
    for (int i = 0; i < NCHAN; i++) v[i*IN_W +: IN_W] = (i % 2 == 0) ? a : b;
    return v;
  endfunction

  function automatic logic [NCHAN*OUT_W-1:0] lanes_out(input logic [OUT_W-1:0] a,
                                                       input logic [OUT_W-1:0] b);
    logic [NCHAN*OUT_W-1:0] v;
    for (int i = 0; i < NCHAN; i++) v[i*OUT_W +: OUT_W] = (i % 2 == 0) ? a : b;
    return v;
  endfunction

  task automatic push(input logic [EXP_W-1:0] e);
    exp_valid = 1'b1;
    exp_in    = e;
    @(posedge clk); #1;
    exp_valid = 1'b0;
  endtask

  task automatic beat(input logic [IN_W-1:0] ra, input logic [IN_W-1:0] rb,
                      input logic [IN_W-1:0] im, input logic pu,
                      input logic [EXP_W-1:0] pe);
    valid_in   = 1'b1;
    data_re_in = lanes_in(ra, rb);
    data_im_in = lanes_in(im, im);
    exp_valid  = pu;
    exp_in     = pe;
    @(posedge clk); #1;
    valid_in  = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic check_beat(input string tag, input logic first,
                            input logic [OUT_W-1:0] ya, input logic [OUT_W-1:0] yb,
                            input logic [OUT_W-1:0] yim);
    chk_bit({tag, "_vld"}, valid_out, 1'b1);
    chk_bit({tag, "_first"}, blk_first, first);
    chk_vec({tag, "_re"}, data_re_out, lanes_out(ya, yb));
    chk_vec({tag, "_im"}, data_im_out, lanes_out(yim, yim));
  endtask

  task automatic block(input string tag, input logic [IN_W-1:0] ra,
                       input logic [IN_W-1:0] rb, input logic [IN_W-1:0] im,
                       input logic [OUT_W-1:0] ya, input logic [OUT_W-1:0] yb,
                       input logic [OUT_W-1:0] yim, input int gap);
    for (int b = 0; b < 4; b++) begin
      beat(ra, rb, im, 1'b0, '0);
      check_beat(tag, (b == 0), ya, yb, yim);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        chk_bit({tag, "_gap"}, valid_out, 1'b0);
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_bit("rst_ready", exp_ready, 1'b1);
    chk_bit("rst_vld", valid_out, 1'b0);
    chk_bit("rst_first", blk_first, 1'b0);
    chk_vec("rst_re", data_re_out, '0);
    chk_vec("rst_im", data_im_out, '0);
    chk_bit("rst_unf", err_underflow, 1'b0);
    chk_bit("rst_ovf", err_overflow, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: s=+2, 100 -> 25, -100 -> -25; outputs hold while idle
    push(5'sd2);
    block("t1", 11'sd100, 11'sd100, -11'sd100, 16'sd25, 16'sd25, -16'sd25, 0);
    @(posedge clk); #1;
    chk_bit("t1_idle_vld", valid_out, 1'b0);
    chk_vec("t1_hold_re", data_re_out, lanes_out(16'sd25, 16'sd25));

    // T2: left shifts and saturation (-16 behaves as -15)
    push(-5'sd3);
    block("t2a", -11'sd1, 11'sd1023, 11'sd511, 16'hFFF8, 16'sd8184, 16'sd4088, 0);
    push(-5'sd15);
    block("t2b", 11'sd511, -11'sd512, 11'sd1, 16'h7FFF, 16'h8000, 16'h7FFF, 0);
    push(-5'sd16);
    block("t2c", 11'sd1, -11'sd1, 11'sd0, 16'h7FFF, 16'h8000, 16'h0000, 0);

    // T3: round half up on right shifts
    push(5'sd1);
    block("t3a", 11'sd3, -11'sd3, 11'sd1, 16'sd2, 16'hFFFF, 16'sd1, 0);
    push(5'sd4);
    block("t3b", -11'sd8, -11'sd9, 11'sd8, 16'sd0, 16'hFFFF, 16'sd1, 0);

    // T4: fill FIFO, overflow drops the fifth push, queued order preserved
    push(5'sd1);
    push(5'sd2);
    push(5'sd3);
    push(5'sd0);
    chk_bit("t4_full_ready", exp_ready, 1'b0);
    chk_bit("t4_ovf_before", err_overflow, 1'b0);
    push(5'sd7);
    chk_bit("t4_ovf_after", err_overflow, 1'b1);
    block("t4a", 11'sd64, 11'sd5, -11'sd64, 16'sd32, 16'sd3, 16'hFFE0, 0);
    chk_bit("t4_ready_again", exp_ready, 1'b1);
    block("t4b", 11'sd64, 11'sd5, -11'sd64, 16'sd16, 16'sd1, 16'hFFF0, 0);
    block("t4c", 11'sd64, 11'sd5, -11'sd64, 16'sd8, 16'sd1, 16'hFFF8, 0);
    block("t4d", 11'sd64, 11'sd5, -11'sd64, 16'sd64, 16'sd5, 16'hFFC0, 0);

    // T5: empty FIFO at block start -> unscaled block and sticky underflow
    chk_bit("t5_unf_before", err_underflow, 1'b0);
    block("t5", 11'sd7, -11'sd7, -11'sd7, 16'sd7, 16'hFFF9, 16'hFFF9, 0);
    chk_bit("t5_unf_after", err_underflow, 1'b1);

    // T6: gappy beats, push and pop in the same cycle, reset mid-block
    push(5'sd2);
    push(5'sd1);
    block("t6a", 11'sd100, 11'sd5, -11'sd100, 16'sd25, 16'sd1, 16'hFFE7, 2);
    for (int b = 0; b < 4; b++) begin
      beat(11'sd100, 11'sd5, -11'sd100, (b == 0), 5'sd3);
      check_beat("t6b", (b == 0), 16'sd50, 16'sd3, 16'hFFCE);
      repeat (2) begin @(posedge clk); #1; end
    end
    chk_bit("t6_ready", exp_ready, 1'b1);
    push(-5'sd1);
    for (int b = 0; b < 3; b++) begin
      beat(11'sd100, 11'sd5, -11'sd100, 1'b0, '0);
      check_beat("t6c", (b == 0), 16'sd13, 16'sd1, 16'hFFF4);
      repeat (2) begin @(posedge clk); #1; end
    end
    rst = 1'b1;
    #2;
    chk_bit("t6_rst_vld", valid_out, 1'b0);
    chk_bit("t6_rst_first", blk_first, 1'b0);
    chk_vec("t6_rst_re", data_re_out, '0);
    chk_vec("t6_rst_im", data_im_out, '0);
    chk_bit("t6_rst_unf", err_underflow, 1'b0);
    chk_bit("t6_rst_ovf", err_overflow, 1'b0);
    chk_bit("t6_rst_ready", exp_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    push(5'sd2);
    beat(11'sd100, 11'sd5, -11'sd100, 1'b0, '0);
    check_beat("t6d", 1'b1, 16'sd25, 16'sd1, 16'hFFE7);
    chk_bit("t6d_unf", err_underflow, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
